// File: rtl/rr_arbiter_16_pkg.sv
// rr_arbiter_16_pkg: shared sizes, FSM encoding and default grant limit for the round-robin arbiter
package rr_arbiter_16_pkg;
    localparam int NUM_REQ = 16;
    localparam int SEL_W = 4;
    localparam int TIMEOUT_DEF = 255;
    localparam logic IDLE = 1'b0;
    localparam logic GRANT = 1'b1;
endpackage

// File: rtl/dec4to16.sv
// dec4to16: 4-to-16 one-hot decoder with enable
module dec4to16 (
    input  logic [3:0]  sel,
    input  logic        en,
    output logic [15:0] y
);
    assign y = en ? 16'(1) << sel : '0;
endmodule

// File: rtl/rr_pick16.sv
// rr_pick16: first set request bit at or after ptr+1, wrapping 15->0
module rr_pick16
    import rr_arbiter_16_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   idx,
    output logic               any
);
    // scan farthest-first so the nearest set bit after ptr wins
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[ptr + SEL_W'(i + 1)]) begin
                idx = ptr + SEL_W'(i + 1);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rr_arbiter_16.sv
// rr_arbiter_16: 16-way round-robin arbiter with done/drop release and grant-length timeout
module rr_arbiter_16
    import rr_arbiter_16_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [SEL_W-1:0]   sel,
    output logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic               timeout,
    output logic               busy
);
    logic               state;
    logic [SEL_W-1:0]   ptr;
    logic [SEL_W-1:0]   idx;
    logic               any;
    logic [CNT_W-1:0]   cnt;
    logic               normal;
    logic               expire;

    rr_pick16 u_pick (.req(req), .ptr(ptr), .idx(idx), .any(any));
    dec4to16 u_dec (.sel(sel), .en(en), .y(grant));

    assign normal = done | ~req[sel];
    assign expire = cnt == CNT_W'(TIMEOUT - 1);
    assign en = state == GRANT;
    assign busy = en;

    // register the pick in IDLE; in GRANT hold until done, drop or limit, then hand priority past sel
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel <= '0;
            ptr <= '1;
            cnt <= '0;
            timeout <= 1'b0;
        end else if (state == IDLE) begin
            timeout <= 1'b0;
            cnt <= '0;
            if (any) begin
                state <= GRANT;
                sel <= idx;
            end
        end else if (normal || expire) begin
            state <= IDLE;
            ptr <= sel;
            timeout <= ~normal;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule
